if_stage: RTL

- Instruction-fetch stage that owns the architectural program counter and drives the instruction-memory request handshake.
- Loads the next PC from the fetch PC-select mux. Exports the current PC back to that mux as its "old PC" operand.
- Delivers fetched instructions into the IF/ID pipeline register, honouring decode stall and redirect flush.

---
 rtl/if_stage_pkg.sv | 37 +++
 rtl/if_id_reg.sv | 39 +++
 rtl/if_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset defaults,
// fetch state encoding and the IF/ID pipeline bundle layout.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // FETCH: request outstanding, result is wanted.
    // DROP:  request outstanding, result is stale and will be thrown away.
    // HOLD:  a fetched word is parked while decode is stalled, no request.
    // 2'd3 is unreachable and steers back to FETCH.
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DROP    = 2'd1,
        HOLD    = 2'd2,
        ILLEGAL = 2'd3
    } fetch_state_e;

    localparam int IF_ID_W = 65;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    // Builds a valid IF/ID entry from a fetched address/instruction pair.
    function automatic logic [IF_ID_W-1:0] make_if_id(input logic [31:0] pc,
                                                      input logic [31:0] instr);
        if_id_t entry;
        entry.valid = 1'b1;
        entry.pc    = pc;
        entry.instr = instr;
        return entry;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Clear beats load, and with neither asserted the
// register holds. An invalid slot always shows NOP_INSTR; the pc field is
// left untouched on clear and only meaningful while valid is set.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [IF_ID_W-1:0] data_in,
    output logic               valid,
    output logic [31:0]        pc,
    output logic [31:0]        instr
);

    if_id_t entry_q;

    // Slot update: reset empties it, clear inserts a bubble, load captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q.valid <= 1'b0;
            entry_q.pc    <= 32'h0000_0000;
            entry_q.instr <= NOP_INSTR;
        end else if (clear) begin
            entry_q.valid <= 1'b0;
            entry_q.instr <= NOP_INSTR;
        end else if (load) begin
            entry_q <= if_id_t'(data_in);
        end
    end

    assign valid = entry_q.valid;
    assign pc    = entry_q.pc;
    assign instr = entry_q.instr;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the architectural PC, runs the instruction
// memory request handshake and feeds the IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] newpc,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    fetch_state_e       state;
    logic [31:0]        pc_q;
    logic [31:0]        addr_q;
    logic [31:0]        buf_pc;
    logic [31:0]        buf_instr;
    logic               req_q;
    logic               ifid_load;
    logic               ifid_clear;
    logic [IF_ID_W-1:0] ifid_data;

    // IF/ID control: decides per state whether the slot loads, clears or holds.
    // A redirect always clears, even under stall.
    always_comb begin
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        ifid_data  = make_if_id(addr_q, imem_rdata);
        case (state)
            FETCH: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                end else if (!stall) begin
                    if (imem_ack) begin
                        ifid_load = 1'b1;
                    end else begin
                        ifid_clear = 1'b1;
                    end
                end
            end
            DROP: begin
                if (redirect || !stall) begin
                    ifid_clear = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    ifid_data = make_if_id(buf_pc, buf_instr);
                end
            end
            default: begin
                ifid_clear = 1'b1;
            end
        endcase
    end

    // Fetch state machine with PC, request address, parking buffer and request flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            buf_pc    <= 32'h0000_0000;
            buf_instr <= NOP_INSTR;
            req_q     <= 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc_q <= newpc;
                        if (redirect || !stall) begin
                            addr_q <= newpc;
                        end else begin
                            buf_pc    <= addr_q;
                            buf_instr <= imem_rdata;
                            state     <= HOLD;
                            req_q     <= 1'b0;
                        end
                    end else if (redirect) begin
                        pc_q  <= newpc;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc_q <= newpc;
                    end
                    if (imem_ack) begin
                        addr_q <= redirect ? newpc : pc_q;
                        state  <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q   <= newpc;
                        addr_q <= newpc;
                        state  <= FETCH;
                        req_q  <= 1'b1;
                    end else if (!stall) begin
                        addr_q <= pc_q;
                        state  <= FETCH;
                        req_q  <= 1'b1;
                    end
                end
                default: begin
                    addr_q <= pc_q;
                    state  <= FETCH;
                    req_q  <= 1'b1;
                end
            endcase
        end
    end

    // No request is presented while reset is held; it appears right after release.
    assign imem_req  = req_q & ~rst;
    assign imem_addr = addr_q;
    assign pc        = pc_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .clear   (ifid_clear),
        .data_in (ifid_data),
        .valid   (if_id_valid),
        .pc      (if_id_pc),
        .instr   (if_id_instr)
    );

endmodule
